// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: byte FIFO feeding an 8N1-style serialiser
// Optional even parity bit after the data bits: define UART_TX_PARITY_EN.
module uart_tx_fifo #(
   parameter int BaudRate     = 115200,
   parameter int DataBitsSize = 8,
   parameter int StopBitsSize = 1,
   parameter int BufferSize   = 16,
   parameter int ClockFreqHz  = 10000000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic [DataBitsSize-1:0]       wr_data,
   input  logic                          clr_overflow,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(BufferSize):0]   level,
   output logic                          overflow,
   output logic                          busy,
   output logic                          tx_sig
);

   localparam int ClkPerBit = ClockFreqHz / BaudRate;
   localparam int PtrW      = $clog2(BufferSize);
   localparam int LvlW      = PtrW + 1;
   localparam int CntW      = $clog2(ClkPerBit);
   localparam int IdxW      = $clog2(DataBitsSize);

   if (ClkPerBit < 2) begin : g_bad_clk_per_bit
      $error("uart_tx_fifo: ClockFreqHz/BaudRate must be at least 2");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                  state, state_n;
   logic [CntW-1:0]         baud_cnt, baud_cnt_n;
   logic [IdxW-1:0]         bit_idx, bit_idx_n;
   logic [DataBitsSize-1:0] tx_data, tx_data_n;
   logic [DataBitsSize-1:0] mem [BufferSize];
   logic [PtrW-1:0]         wr_ptr, rd_ptr;
   logic                    push, pop, bit_done, last_data, last_stop;

   assign full      = (level == LvlW'(BufferSize));
   assign empty     = (level == '0);
   assign busy      = (state != IDLE);
   assign push      = wr_en && !full;
   assign bit_done  = (baud_cnt == CntW'(ClkPerBit - 1));
   assign last_data = (bit_idx == IdxW'(DataBitsSize - 1));
   assign last_stop = (bit_idx == IdxW'(StopBitsSize - 1));

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
         case ({push, pop})
            2'b10:   level <= level + LvlW'(1);
            2'b01:   level <= level - LvlW'(1);
            default: level <= level;
         endcase
         // A drop in the same cycle as a clear must leave the flag set.
         if (wr_en && full)     overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         tx_data  <= '0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         tx_data  <= tx_data_n;
      end
   end

   always_comb begin
      state_n    = state;
      baud_cnt_n = bit_done ? '0 : baud_cnt + CntW'(1);
      bit_idx_n  = bit_idx;
      tx_data_n  = tx_data;
      pop        = 1'b0;
      tx_sig     = 1'b1;
      case (state)
         IDLE: begin
            baud_cnt_n = '0;
            bit_idx_n  = '0;
            if (!empty) begin
               pop       = 1'b1;
               tx_data_n = mem[rd_ptr];
               state_n   = START;
            end
         end
         START: begin
            tx_sig = 1'b0;
            if (bit_done) state_n = DATA;
         end
         DATA: begin
            tx_sig = tx_data[bit_idx];
            if (bit_done) begin
               if (last_data) begin
                  bit_idx_n = '0;
`ifdef UART_TX_PARITY_EN
                  state_n   = PARITY;
`else
                  state_n   = STOP;
`endif
               end else begin
                  bit_idx_n = bit_idx + IdxW'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_sig = ^tx_data;
            if (bit_done) state_n = STOP;
         end
`endif
         STOP: begin
            if (bit_done) begin
               if (last_stop) begin
                  bit_idx_n = '0;
                  // Chain straight into the next start bit when data is waiting.
                  if (!empty) begin
                     pop       = 1'b1;
                     tx_data_n = mem[rd_ptr];
                     state_n   = START;
                  end else begin
                     state_n   = IDLE;
                  end
               end else begin
                  bit_idx_n = bit_idx + IdxW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo
// Frame-level reference model predicts FIFO status and line; a monitor decodes frames.
module tb_uart_tx_fifo;

   localparam int CPB = 10;
   localparam int DB  = 8;
   localparam int SB  = 1;
   localparam int BUF = 16;
`ifdef UART_TX_PARITY_EN
   localparam int PB  = 1;
`else
   localparam int PB  = 0;
`endif
   localparam int FRAME = (1 + DB + PB + SB) * CPB;

   logic       clk, rst_n, wr_en, clr_overflow;
   logic [7:0] wr_data;
   logic       full, empty, overflow, busy, tx_sig;
   logic [4:0] level;

   uart_tx_fifo #(
      .BaudRate(100000), .DataBitsSize(DB), .StopBitsSize(SB),
      .BufferSize(BUF), .ClockFreqHz(1000000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .clr_overflow(clr_overflow), .full(full), .empty(empty), .level(level),
      .overflow(overflow), .busy(busy), .tx_sig(tx_sig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model state: occupancy, queued bytes, and the most recent frame start.
   int         occ      = 0;
   bit         ovf      = 1'b0;
   int         last_pop = -1000000;
   int         ready_at = 0;
   logic [7:0] cur      = '0;
   logic [7:0] mfifo[$];
   logic [7:0] sb[$];

   always @(negedge clk) begin
      bit   in_frame, exp_tx, do_pop, do_push, drop;
      int   k;
      cyc++;
      if (!rst_n) begin
         occ = 0; ovf = 1'b0; last_pop = -1000000; ready_at = 0;
         mfifo.delete(); sb.delete();
      end
      in_frame = (cyc > last_pop) && (cyc <= last_pop + FRAME);
      exp_tx   = 1'b1;
      if (in_frame) begin
         k = (cyc - last_pop - 1) / CPB;
         if (k == 0)                       exp_tx = 1'b0;
         else if (k <= DB)                 exp_tx = cur[k-1];
         else if (PB == 1 && k == DB + 1)  exp_tx = ^cur;
      end
      check("level",    32'(level),    32'(occ));
      check("full",     32'(full),     32'(occ == BUF));
      check("empty",    32'(empty),    32'(occ == 0));
      check("overflow", 32'(overflow), 32'(ovf));
      check("busy",     32'(busy),     32'(in_frame));
      check("tx_sig",   32'(tx_sig),   32'(exp_tx));
      if (rst_n) begin
         do_pop  = (cyc >= ready_at) && (occ > 0);
         do_push = wr_en && (occ < BUF);
         drop    = wr_en && (occ == BUF);
         if (do_push) mfifo.push_back(wr_data);
         if (do_pop) begin
            cur      = mfifo.pop_front();
            sb.push_back(cur);
            last_pop = cyc;
            ready_at = cyc + FRAME;
         end
         occ = occ + int'(do_push) - int'(do_pop);
         if (drop)              ovf = 1'b1;
         else if (clr_overflow) ovf = 1'b0;
      end
   end

   // Line monitor: samples each bit mid-cell and checks the byte against the scoreboard.
   int         mon_cnt = -1;
   logic [7:0] mon_byte;
   always @(negedge clk) begin
      int   k;
      bit   done;
      done = 1'b0;
      if (!rst_n) begin
         mon_cnt = -1;
      end else begin
         if (mon_cnt < 0 && tx_sig === 1'b0) mon_cnt = 0;
         if (mon_cnt >= 0) begin
            if (mon_cnt % CPB == CPB / 2) begin
               k = mon_cnt / CPB;
               if (k == 0)                      check("mon_start", 32'(tx_sig), 32'd0);
               else if (k <= DB)                mon_byte[k-1] = tx_sig;
               else if (PB == 1 && k == DB + 1) check("mon_parity", 32'(tx_sig), 32'(^mon_byte));
               else begin
                  check("mon_stop", 32'(tx_sig), 32'd1);
                  if (sb.size() == 0) check("mon_unexpected_frame", 32'(mon_byte), 32'hFFFF_FFFF);
                  else                check("mon_byte", 32'(mon_byte), 32'(sb.pop_front()));
                  done = 1'b1;
               end
            end
            mon_cnt++;
            if (done) mon_cnt = -1;
         end
      end
   end

   task automatic drive(input bit en, input logic [7:0] d, input bit clr);
      @(posedge clk);
      #1;
      wr_en = en; wr_data = d; clr_overflow = clr;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((occ > 0 || cyc <= last_pop + FRAME + 2 || mon_cnt >= 0) && n < 20000) begin
         idle(1);
         n++;
      end
      check("drain_timeout", 32'(n < 20000), 32'd1);
      check("sb_leftover", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; clr_overflow = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      drive(1'b1, 8'h55, 1'b0);
      idle(1);
      wait_drain();

      drive(1'b1, 8'h41, 1'b0);
      drive(1'b1, 8'h42, 1'b0);
      idle(1);
      wait_drain();

      for (int i = 0; i < 20; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0);
      idle(3);
      drive(1'b0, 8'h00, 1'b1);
      idle(3);
      wait_drain();

      drive(1'b1, 8'h07, 1'b0);
      drive(1'b1, 8'h03, 1'b0);
      idle(1);
      wait_drain();

      for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0);
      idle(40);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(300);

      for (int blk = 0; blk < 12; blk++) begin
         int p;
         p = (blk % 2 == 1) ? 40 : 2;
         for (int i = 0; i < 400; i++)
            drive(1'b1 && ($urandom_range(0, 99) < p), 8'($urandom), $urandom_range(0, 149) == 0);
      end
      idle(1);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
